// File: rtl/ground_pkg.sv
// ---------------------------------------------------------------------------
// ground_pkg
// Constants and types shared by the ground generator and its consumers.
//   STATE_W     : width of the ground state vector (1 = lava, 0 = ground)
//   VIS_OFFSET  : index of the first visible state bit
//   SCREEN_W    : visible width in pixels
//   GROUND_Y    : first ground row; feet on GROUND_Y-1 means grounded
//   PLAYER_W    : player footprint width in columns
//   LAVA_THRESH : lava columns under a grounded player that kill it
// ---------------------------------------------------------------------------
package ground_pkg;

   localparam int STATE_W     = 440;
   localparam int VIS_OFFSET  = 80;
   localparam int SCREEN_W    = 360;
   localparam int GROUND_Y    = 160;
   localparam int PLAYER_W    = 16;
   localparam int LAVA_THRESH = 8;

   // Ground colour codes (3-bit RGB) used by the renderer side.
   localparam logic [2:0] COLOUR_GROUND = 3'b010;
   localparam logic [2:0] COLOUR_LAVA   = 3'b100;
   localparam logic [2:0] COLOUR_SKY    = 3'b001;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SCAN   = 2'd1,
      ST_DECIDE = 2'd2
   } gc_state_t;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [15:0] sat_inc16(input logic [15:0] value);
      logic [15:0] result;
      if (value == 16'hFFFF) begin
         result = value;
      end else begin
         result = value + 16'd1;
      end
      return result;
   endfunction

endpackage

// File: rtl/ground_col_lookup.sv
// ---------------------------------------------------------------------------
// ground_col_lookup
// Maps a screen column to its lava bit in a ground snapshot.
//   snapshot : ground state vector (STATE_W bits)
//   column   : screen column, 10 bits so footprint sums never wrap
//   lava     : 1 when the column is lava; columns 0 and > SCREEN_W read
//              as ground and never index the vector
// ---------------------------------------------------------------------------
module ground_col_lookup
   import ground_pkg::*;
(
   input  logic [STATE_W-1:0] snapshot,
   input  logic [9:0]         column,
   output logic               lava
);

   logic [8:0] index_s;

   // Column X sits at bit VIS_OFFSET + SCREEN_W - X, i.e. STATE_W - X.
   assign index_s = 9'(10'(VIS_OFFSET + SCREEN_W) - column);

   // Range-guarded bit select.
   always_comb begin
      lava = 1'b0;
      if ((column == 10'd0) || (column > 10'(SCREEN_W))) begin
         lava = 1'b0;
      end else begin
         lava = snapshot[index_s];
      end
   end

endmodule

// File: rtl/ground_collision.sv
// ---------------------------------------------------------------------------
// ground_collision
// Once per frame, snapshots the ground state and scans the PLAYER_W columns
// under the player's feet (one per clock), reports the lava count and keeps
// a sticky death flag plus a saturating survived-frame counter.
//   clock, resetn     : clock, asynchronous active-low reset
//   new_frame         : one-cycle strobe, starts a scan (ignored when busy)
//   state_in          : ground state vector, 1 = lava
//   player_x/player_y : leftmost footprint column / feet row
//   clear_death       : clears death, frames_survived and overrun
//   busy              : scan in progress
//   done              : one-cycle pulse, results valid
//   lava_count/on_lava: lava columns under footprint at last scan
//   death             : sticky death flag
//   overrun           : sticky, new_frame seen while busy
//   frames_survived   : completed scans without death, saturating
// ---------------------------------------------------------------------------
module ground_collision
   import ground_pkg::*;
(
   input  logic               clock,
   input  logic               resetn,
   input  logic               new_frame,
   input  logic [STATE_W-1:0] state_in,
   input  logic [8:0]         player_x,
   input  logic [7:0]         player_y,
   input  logic               clear_death,
   output logic               busy,
   output logic               done,
   output logic [4:0]         lava_count,
   output logic               on_lava,
   output logic               death,
   output logic               overrun,
   output logic [15:0]        frames_survived
);

   localparam logic [3:0] LAST_K     = 4'(PLAYER_W - 1);
   localparam logic [7:0] FEET_GND_Y = 8'(GROUND_Y - 1);
   localparam logic [4:0] THRESH     = 5'(LAVA_THRESH);

   gc_state_t          state_r;
   gc_state_t          state_nxt_s;
   logic [STATE_W-1:0] snap_r;
   logic [8:0]         px_r;
   logic [7:0]         py_r;
   logic [3:0]         k_r;
   logic [4:0]         acc_r;
   logic [9:0]         col_s;
   logic               col_lava_s;
   logic               start_s;
   logic               scan_s;
   logic               decide_s;
   logic               kill_s;

   // Column under test, widened so player_x + k cannot wrap.
   assign col_s = {1'b0, px_r} + {6'd0, k_r};

   ground_col_lookup u_lookup (
      .snapshot (snap_r),
      .column   (col_s),
      .lava     (col_lava_s)
   );

   // FSM state register.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state and per-state control strobes.
   always_comb begin
      state_nxt_s = state_r;
      start_s     = 1'b0;
      scan_s      = 1'b0;
      decide_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (new_frame) begin
               start_s     = 1'b1;
               state_nxt_s = ST_SCAN;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_SCAN: begin
            scan_s = 1'b1;
            if (k_r == LAST_K) begin
               state_nxt_s = ST_DECIDE;
            end else begin
               state_nxt_s = ST_SCAN;
            end
         end
         ST_DECIDE: begin
            decide_s    = 1'b1;
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Death only for a grounded player over at least THRESH lava columns.
   assign kill_s = decide_s && (py_r >= FEET_GND_Y) && (acc_r >= THRESH);

   // Snapshot, column counter and lava accumulator.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         snap_r <= '0;
         px_r   <= 9'd0;
         py_r   <= 8'd0;
         k_r    <= 4'd0;
         acc_r  <= 5'd0;
      end else if (start_s) begin
         snap_r <= state_in;
         px_r   <= player_x;
         py_r   <= player_y;
         k_r    <= 4'd0;
         acc_r  <= 5'd0;
      end else if (scan_s) begin
         k_r    <= k_r + 4'd1;
         acc_r  <= acc_r + {4'd0, col_lava_s};
      end
   end

   // Scan status and per-scan results.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         busy       <= 1'b0;
         done       <= 1'b0;
         lava_count <= 5'd0;
         on_lava    <= 1'b0;
      end else begin
         done <= decide_s;
         if (start_s) begin
            busy <= 1'b1;
         end else if (decide_s) begin
            busy       <= 1'b0;
            lava_count <= acc_r;
            on_lava    <= (acc_r != 5'd0);
         end
      end
   end

   // Sticky flags and survival counter; a death set beats clear_death.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         death           <= 1'b0;
         overrun         <= 1'b0;
         frames_survived <= 16'd0;
      end else begin
         if (kill_s) begin
            death <= 1'b1;
         end else if (clear_death) begin
            death <= 1'b0;
         end

         if (new_frame && busy) begin
            overrun <= 1'b1;
         end else if (clear_death) begin
            overrun <= 1'b0;
         end

         if (clear_death) begin
            frames_survived <= 16'd0;
         end else if (decide_s && !kill_s && !death) begin
            frames_survived <= sat_inc16(frames_survived);
         end
      end
   end

endmodule

// File: tb/tb_ground_collision.sv
// Scoreboard bench: the stimulus side computes each scan's expected result
// from the column/lava rules and queues it; a monitor compares on done.
module tb_ground_collision;

   logic         clock = 1'b0;
   logic         resetn;
   logic         new_frame;
   logic [439:0] state_in;
   logic [8:0]   player_x;
   logic [7:0]   player_y;
   logic         clear_death;
   logic         busy, done, on_lava, death, overrun;
   logic [4:0]   lava_count;
   logic [15:0]  frames_survived;

   ground_collision dut (
      .clock           (clock),
      .resetn          (resetn),
      .new_frame       (new_frame),
      .state_in        (state_in),
      .player_x        (player_x),
      .player_y        (player_y),
      .clear_death     (clear_death),
      .busy            (busy),
      .done            (done),
      .lava_count      (lava_count),
      .on_lava         (on_lava),
      .death           (death),
      .overrun         (overrun),
      .frames_survived (frames_survived)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      int lc;
      int ol;
      int dth;
      int fs;
      int issue;
   } exp_t;

   exp_t q[$];
   int   n_total = 0;
   int   n_pass  = 0;
   int   n_done  = 0;
   int   m_death = 0;
   int   m_frames = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // Reference: count lava among screen columns px..px+15, off-screen = ground.
   function automatic int model_lava(input logic [439:0] v, input int px);
      int n = 0;
      for (int i = 0; i < 16; i++) begin
         int x = px + i;
         if (x >= 1 && x <= 360) n += int'(v[440 - x]);
      end
      return n;
   endfunction

   function automatic logic [439:0] lava_cols(input int xlo, input int xhi);
      logic [439:0] v = '0;
      for (int x = xlo; x <= xhi; x++) v[440 - x] = 1'b1;
      return v;
   endfunction

   // Monitor: every done pulse must match the oldest queued expectation.
   always @(negedge clock) begin
      if (resetn === 1'b1 && done === 1'b1) begin
         exp_t e;
         n_done++;
         if (q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_done: got done=1, expected no pending scan (t=%0t)", $time);
         end else begin
            e = q.pop_front();
            chk("lava_count", int'(lava_count), e.lc);
            chk("on_lava", int'(on_lava), e.ol);
            chk("death", int'(death), e.dth);
            chk("frames_survived", int'(frames_survived), e.fs);
            // latency counted to the first posedge that samples done high
            chk("done_latency", cyc + 1 - e.issue, 18);
         end
      end
   end

   task automatic start_scan(input logic [439:0] v, input int px, input int py);
      exp_t e;
      int lava;
      @(negedge clock);
      state_in  = v;
      player_x  = 9'(px);
      player_y  = 8'(py);
      new_frame = 1'b1;
      e.issue = cyc + 1;
      lava = model_lava(v, px);
      if (py >= 159 && lava >= 8) m_death = 1;
      else if (m_death == 0 && m_frames < 65535) m_frames++;
      e.lc = lava;
      e.ol = (lava != 0) ? 1 : 0;
      e.dth = m_death;
      e.fs = m_frames;
      q.push_back(e);
      @(negedge clock);
      new_frame = 1'b0;
   endtask

   task automatic wait_done();
      int start = n_done;
      for (int k = 0; k < 40; k++) begin
         if (n_done != start) break;
         @(negedge clock);
         #1;
      end
      if (n_done == start) begin
         n_total++;
         $display("FAIL done_timeout: got no done, expected done within 40 cycles (t=%0t)", $time);
      end
   endtask

   task automatic scan(input logic [439:0] v, input int px, input int py);
      start_scan(v, px, py);
      wait_done();
   endtask

   task automatic do_clear();
      @(negedge clock);
      clear_death = 1'b1;
      @(negedge clock);
      clear_death = 1'b0;
      m_death = 0;
      m_frames = 0;
      chk("clear_death", int'(death), 0);
      chk("clear_frames", int'(frames_survived), 0);
      chk("clear_overrun", int'(overrun), 0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_done"}, int'(done), 0);
      chk({tag, "_lava_count"}, int'(lava_count), 0);
      chk({tag, "_on_lava"}, int'(on_lava), 0);
      chk({tag, "_death"}, int'(death), 0);
      chk({tag, "_overrun"}, int'(overrun), 0);
      chk({tag, "_frames"}, int'(frames_survived), 0);
   endtask

   initial begin
      logic [439:0] ones;
      logic [439:0] v;
      ones = '1;
      resetn = 1'b0; new_frame = 1'b0; state_in = '0;
      player_x = 9'd0; player_y = 8'd0; clear_death = 1'b0;
      repeat (3) @(negedge clock);
      chk_all_zero("reset");
      resetn = 1'b1;

      // Directed cases
      scan('0, 100, 159);
      do_clear();
      scan(lava_cols(100, 115), 100, 159);
      do_clear();
      scan(lava_cols(100, 107), 100, 159);
      do_clear();
      scan(lava_cols(100, 106), 100, 159);
      scan(ones, 350, 100);
      scan(ones, 0, 100);
      scan(ones, 500, 159);

      // new_frame during a scan: ignored, flagged, snapshot preserved
      start_scan(ones, 100, 159);
      chk("busy_during_scan", int'(busy), 1);
      repeat (4) @(negedge clock);
      new_frame = 1'b1;
      state_in  = '0;
      @(negedge clock);
      new_frame = 1'b0;
      wait_done();
      chk("overrun_set", int'(overrun), 1);
      repeat (25) @(negedge clock);

      // Reset in the middle of a scan: everything clears, no done
      start_scan('0, 100, 159);
      repeat (9) @(negedge clock);
      #2;
      resetn = 1'b0;
      q.delete();
      m_death = 0;
      m_frames = 0;
      #1;
      chk_all_zero("midscan_reset");
      @(negedge clock);
      resetn = 1'b1;
      repeat (30) @(negedge clock);
      scan(lava_cols(100, 103), 100, 159);

      // Randomized scans
      for (int it = 0; it < 40; it++) begin
         int mode, px, py, a;
         if ($urandom_range(0, 4) == 0) do_clear();
         mode = $urandom_range(0, 3);
         px = $urandom_range(0, 511);
         py = $urandom_range(150, 170);
         case (mode)
            0: v = '0;
            1: v = ones;
            2: begin
               for (int i = 0; i < 440; i++) v[i] = 1'($urandom_range(0, 1));
            end
            default: begin
               px = $urandom_range(0, 370);
               a = px + $urandom_range(0, 8);
               v = lava_cols(a, a + $urandom_range(4, 10));
            end
         endcase
         scan(v, px, py);
      end

      repeat (5) @(negedge clock);
      chk("queue_empty", q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, expected finish before 200us");
      $fatal(1);
   end

endmodule
